dot_matrix_scanner: RTL and testbench

- Parametrised successor to the single-panel digit scanner.
- Time-multiplexes a 10-column x 7-row LED dot matrix, replicated across N_PANELS panels, and shows one decimal glyph.
- Adds configurable scan/step timing, per-column blanking (anti-ghosting), tear-free digit update at frame boundaries, up/down/hold/external-load modes with a valid/ready load port, and selectable row polarity.
- Sits between board-level control logic and the matrix column/row drivers.

---
 rtl/dot_matrix_pkg.sv | 63 ++++++
 rtl/dot_font_rom.sv | 17 +
 rtl/dot_matrix_scanner.sv | 190 +++++++++++++++++++
 tb/tb_dot_matrix_scanner.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_matrix_pkg.sv
// Shared types, mode encodings and the 10x7 decimal font
// for the dot-matrix scanner.
package dot_matrix_pkg;

    localparam int N_COLS = 10;
    localparam int N_ROWS = 7;

    localparam logic [3:0] COL_LAST  = 4'd9;
    localparam logic [3:0] DIGIT_MAX = 4'd9;

    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_LOAD = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        LD_CLOSED = 2'b00,
        LD_OPEN   = 2'b01,
        LD_HELD   = 2'b10
    } ld_state_e;

    typedef logic [N_ROWS-1:0] glyph_t;
    typedef glyph_t font_t [10][N_COLS];

    // Bit n of a glyph column lights row n; index is [digit][column].
    localparam font_t FONT = '{
        '{7'h3E, 7'h41, 7'h41, 7'h41, 7'h41,
          7'h41, 7'h41, 7'h41, 7'h41, 7'h3E},
        '{7'h0C, 7'h06, 7'h03, 7'h7F, 7'h7F,
          7'h00, 7'h00, 7'h00, 7'h00, 7'h00},
        '{7'h62, 7'h51, 7'h51, 7'h49, 7'h49,
          7'h49, 7'h45, 7'h45, 7'h43, 7'h42},
        '{7'h22, 7'h41, 7'h41, 7'h49, 7'h49,
          7'h49, 7'h49, 7'h49, 7'h49, 7'h36},
        '{7'h18, 7'h14, 7'h14, 7'h12, 7'h12,
          7'h11, 7'h7F, 7'h7F, 7'h10, 7'h10},
        '{7'h27, 7'h45, 7'h45, 7'h45, 7'h45,
          7'h45, 7'h45, 7'h45, 7'h45, 7'h39},
        '{7'h3E, 7'h49, 7'h49, 7'h49, 7'h49,
          7'h49, 7'h49, 7'h49, 7'h49, 7'h32},
        '{7'h01, 7'h01, 7'h71, 7'h09, 7'h09,
          7'h05, 7'h05, 7'h03, 7'h03, 7'h01},
        '{7'h3E, 7'h49, 7'h49, 7'h49, 7'h49,
          7'h49, 7'h49, 7'h49, 7'h49, 7'h3E},
        '{7'h26, 7'h49, 7'h49, 7'h49, 7'h49,
          7'h49, 7'h49, 7'h49, 7'h49, 7'h3E}
    };

    function automatic logic [3:0] digit_step(
        input logic [3:0] d,
        input logic       up
    );
        logic [3:0] r;
        if (up)
            r = (d >= DIGIT_MAX) ? 4'd0 : d + 4'd1;
        else
            r = (d == 4'd0) ? DIGIT_MAX : d - 4'd1;
        return r;
    endfunction

endpackage

// File: rtl/dot_font_rom.sv
// Combinational glyph lookup: (digit, column) -> 7-bit row pattern.
// Out-of-range digits or columns read as an unlit column.
module dot_font_rom
    import dot_matrix_pkg::*;
(
    input  logic [3:0] digit,
    input  logic [3:0] col,
    output glyph_t     glyph
);

    always_comb begin
        glyph = '0;
        if (digit <= DIGIT_MAX && col <= COL_LAST)
            glyph = FONT[digit][col];
    end

endmodule

// File: rtl/dot_matrix_scanner.sv
// Multi-panel 10x7 dot-matrix scanner showing one decimal glyph,
// with frame-aligned digit updates and a valid/ready load port.
module dot_matrix_scanner
    import dot_matrix_pkg::*;
#(
    parameter int SCAN_DIV       = 6000,
    parameter int STEP_DIV       = 24000000,
    parameter int BLANK_CYC      = 16,
    parameter int N_PANELS       = 2,
    parameter int ROW_ACTIVE_LOW = 1
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [1:0]                 MODE,
    input  logic                       PAUSE,
    input  logic                       LOAD_VALID,
    input  logic [3:0]                 LOAD_DIGIT,
    output logic                       LOAD_READY,
    output logic                       LOAD_ERR,
    output logic [3:0]                 DIGIT,
    output logic                       FRAME_DONE,
    output logic [N_COLS-1:0]          DOT_COL,
    output logic [N_ROWS*N_PANELS-1:0] DOT_RAW
);

    localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int TW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;

    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] BLANK_END = SW'(BLANK_CYC);
    localparam logic [TW-1:0] STEP_LAST = TW'(STEP_DIV - 1);

    localparam logic [N_COLS-1:0] COL_ONE = 1;
    localparam glyph_t ROW_OFF =
        (ROW_ACTIVE_LOW != 0) ? {N_ROWS{1'b1}} : {N_ROWS{1'b0}};

    mode_e           mode;
    mode_e           mode_q;
    ld_state_e       ld_state;
    ld_state_e       ld_next;

    logic [SW-1:0]   scan_cnt;
    logic [3:0]      col;
    logic [TW-1:0]   step_cnt;
    logic            step_pend;
    logic [3:0]      pend_dig;
    logic [3:0]      digit;
    logic [3:0]      digit_nx;

    glyph_t          glyph;
    glyph_t          row_lit;

    logic            slot_end;
    logic            frame_end;
    logic            blank;
    logic            mode_chg;
    logic            counting;
    logic            step_tc;
    logic            hs;
    logic            hs_ok;
    logic            hs_bad;
    logic            pend_vld;
    logic            apply_load;
    logic            apply_step;
    logic            apply_up;
    logic            apply_dn;

    assign mode      = mode_e'(MODE);
    assign slot_end  = scan_cnt == SCAN_LAST;
    assign frame_end = slot_end && col == COL_LAST;
    assign blank     = scan_cnt < BLANK_END;
    assign mode_chg  = mode != mode_q;

    assign counting = (mode == MODE_UP || mode == MODE_DOWN)
                   && !PAUSE && !mode_chg;
    assign step_tc  = counting && step_cnt == STEP_LAST;

    assign LOAD_READY = ld_state == LD_OPEN && mode == MODE_LOAD;
    assign hs         = LOAD_VALID && LOAD_READY;
    assign hs_ok      = hs && LOAD_DIGIT <= DIGIT_MAX;
    assign hs_bad     = hs && LOAD_DIGIT > DIGIT_MAX;
    assign pend_vld   = ld_state == LD_HELD;

    // Digit only moves on the frame wrap so a frame never tears.
    assign apply_load = frame_end && mode == MODE_LOAD && pend_vld;
    assign apply_step = frame_end && step_pend && !PAUSE && !mode_chg;
    assign apply_up   = apply_step && mode == MODE_UP;
    assign apply_dn   = apply_step && mode == MODE_DOWN;

    assign DIGIT = digit;

    dot_font_rom u_rom (
        .digit (digit),
        .col   (col),
        .glyph (glyph)
    );

    assign row_lit = (blank ? '0 : glyph) ^ ROW_OFF;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            scan_cnt <= '0;
            col      <= '0;
        end else if (slot_end) begin
            scan_cnt <= '0;
            col      <= (col == COL_LAST) ? 4'd0 : col + 4'd1;
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            step_cnt  <= '0;
            step_pend <= 1'b0;
            mode_q    <= mode;
        end else begin
            mode_q <= mode;
            if (mode_chg) begin
                step_cnt  <= '0;
                step_pend <= 1'b0;
            end else begin
                if (counting)
                    step_cnt <= step_tc ? '0 : step_cnt + TW'(1);
                // A new tick wins over consuming the old one.
                if (step_tc)
                    step_pend <= 1'b1;
                else if (apply_up || apply_dn)
                    step_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET)
            ld_state <= LD_CLOSED;
        else
            ld_state <= ld_next;
    end

    always_comb begin
        ld_next = ld_state;
        if (mode != MODE_LOAD) begin
            ld_next = LD_CLOSED;
        end else begin
            unique case (ld_state)
                LD_CLOSED: ld_next = LD_OPEN;
                LD_OPEN:   ld_next = hs_ok ? LD_HELD : LD_OPEN;
                LD_HELD:   ld_next = apply_load ? LD_CLOSED : LD_HELD;
                default:   ld_next = LD_CLOSED;
            endcase
        end
    end

    always_comb begin
        digit_nx = digit;
        unique case (1'b1)
            apply_load: digit_nx = pend_dig;
            apply_up:   digit_nx = digit_step(digit, 1'b1);
            apply_dn:   digit_nx = digit_step(digit, 1'b0);
            default:    digit_nx = digit;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            digit    <= '0;
            pend_dig <= '0;
        end else begin
            digit <= digit_nx;
            if (hs_ok)
                pend_dig <= LOAD_DIGIT;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            DOT_COL    <= '0;
            DOT_RAW    <= {N_PANELS{ROW_OFF}};
            FRAME_DONE <= 1'b0;
            LOAD_ERR   <= 1'b0;
        end else begin
            DOT_COL    <= blank ? '0 : COL_ONE << col;
            DOT_RAW    <= {N_PANELS{row_lit}};
            FRAME_DONE <= frame_end;
            LOAD_ERR   <= hs_bad;
        end
    end

endmodule

// File: tb/tb_dot_matrix_scanner.sv
// Self-checking bench for dot_matrix_scanner: directed scenarios plus
// random traffic against a cycle-position reference model.
module tb_dot_matrix_scanner;
    import dot_matrix_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [1:0]  MODE = 2'b11;
    logic        PAUSE = 1'b0;
    logic        LOAD_VALID = 1'b0;
    logic [3:0]  LOAD_DIGIT = 4'd0;
    logic        LOAD_READY;
    logic        LOAD_ERR;
    logic [3:0]  DIGIT;
    logic        FRAME_DONE;
    logic [9:0]  DOT_COL;
    logic [13:0] DOT_RAW;

    always #5 CLK = ~CLK;

    dot_matrix_scanner #(
        .SCAN_DIV       (8),
        .STEP_DIV       (200),
        .BLANK_CYC      (2),
        .N_PANELS       (2),
        .ROW_ACTIVE_LOW (1)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .MODE       (MODE),
        .PAUSE      (PAUSE),
        .LOAD_VALID (LOAD_VALID),
        .LOAD_DIGIT (LOAD_DIGIT),
        .LOAD_READY (LOAD_READY),
        .LOAD_ERR   (LOAD_ERR),
        .DIGIT      (DIGIT),
        .FRAME_DONE (FRAME_DONE),
        .DOT_COL    (DOT_COL),
        .DOT_RAW    (DOT_RAW)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: position since reset, digit, pending load/step.
    int          age;
    int          m_dig;
    int          m_pd;
    int          m_step;
    int          m_prev;
    bit          m_pv;
    bit          m_sp;
    bit          m_rdy;
    logic [9:0]  e_col;
    logic [13:0] e_raw;
    bit          e_fd;
    bit          e_err;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        int p;
        int c;
        bit fe;
        bit hs_ok;
        bit chg;
        bit fired;
        bit rdy_nx;
        logic [6:0] g;
        if (RESET) begin
            age = 0; m_dig = 0; m_pd = 0; m_step = 0;
            m_pv = 0; m_sp = 0; m_rdy = 0; m_prev = int'(MODE);
            e_col = '0; e_raw = '1; e_fd = 0; e_err = 0;
            return;
        end
        p = age % 80;
        c = p / 8;
        fe = (p == 79);
        g = (p % 8 < 2) ? 7'h00 : FONT[m_dig][c];
        e_col = (p % 8 < 2) ? 10'd0 : (10'd1 << c);
        e_raw = {~g, ~g};
        e_fd = fe;
        hs_ok = LOAD_VALID && m_rdy && MODE == 2 && LOAD_DIGIT <= 9;
        e_err = LOAD_VALID && m_rdy && MODE == 2 && LOAD_DIGIT > 9;
        chg = int'(MODE) != m_prev;
        fired = 0;
        if (chg) begin
            m_step = 0;
            m_sp = 0;
        end else if (MODE < 2 && !PAUSE) begin
            m_step++;
            if (m_step == 200) begin
                m_step = 0;
                fired = 1;
            end
        end
        if (fe && !chg && !PAUSE && MODE < 2 && m_sp) begin
            m_dig = (MODE == 0) ? (m_dig + 1) % 10 : (m_dig + 9) % 10;
            m_sp = 0;
        end
        if (fired) m_sp = 1;
        rdy_nx = (MODE == 2) && !m_pv && !hs_ok;
        if (fe && MODE == 2 && m_pv) begin
            m_dig = m_pd;
            m_pv = 0;
        end
        if (MODE != 2) m_pv = 0;
        else if (hs_ok) begin
            m_pv = 1;
            m_pd = int'(LOAD_DIGIT);
        end
        m_rdy = rdy_nx;
        m_prev = int'(MODE);
        age++;
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
        check("DOT_COL", 32'(DOT_COL), 32'(e_col));
        check("DOT_RAW", 32'(DOT_RAW), 32'(e_raw));
        check("FRAME_DONE", 32'(FRAME_DONE), 32'(e_fd));
        check("LOAD_ERR", 32'(LOAD_ERR), 32'(e_err));
        check("DIGIT", 32'(DIGIT), m_dig);
        check("LOAD_READY", 32'(LOAD_READY), 32'(m_rdy && MODE == 2));
    endtask

    task automatic do_reset(input logic [1:0] md);
        RESET = 1'b1;
        MODE = md;
        PAUSE = 1'b0;
        LOAD_VALID = 1'b0;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    initial begin
        int fdc;
        int chg_n;
        int aligned;
        int cols;
        int i;
        bit saw9;
        logic [3:0] prev;

        do_reset(2'b11);
        check("rst_raw0", 32'(DOT_RAW), 32'h3FFF);
        repeat (3) tick();
        check("col0_d0_raw", 32'(DOT_RAW), 32'(14'b1000001_1000001));
        check("col0_onehot", 32'(DOT_COL), 32'h001);
        fdc = 0;
        repeat (80) begin
            tick();
            fdc += int'(FRAME_DONE);
            if (age == 80) check("col9_onehot", 32'(DOT_COL), 32'h200);
        end
        check("frame_done_cnt", fdc, 1);

        do_reset(2'b00);
        chg_n = 0; aligned = 0; saw9 = 0; prev = DIGIT;
        repeat (2200) begin
            tick();
            if (DIGIT != prev) begin
                chg_n++;
                if (FRAME_DONE && age % 80 == 0) aligned++;
                prev = DIGIT;
            end
            if (DIGIT == 4'd9) saw9 = 1;
        end
        check("up_changes", chg_n, 10);
        check("up_aligned", aligned, 10);
        check("up_saw9", 32'(saw9), 1);
        check("up_wrap", 32'(DIGIT), 0);

        do_reset(2'b01);
        i = 0;
        while (DIGIT == 4'd0 && i < 300) begin
            tick();
            i++;
        end
        check("down_first", 32'(DIGIT), 9);
        PAUSE = 1'b1;
        cols = 0;
        repeat (400) begin
            tick();
            if (DOT_COL != '0) cols++;
        end
        check("pause_hold", 32'(DIGIT), 9);
        check("pause_scan", cols, 300);
        PAUSE = 1'b0;

        do_reset(2'b10);
        tick();
        check("ready_after_rst", 32'(LOAD_READY), 1);
        while (age % 80 != 30) tick();
        LOAD_DIGIT = 4'd1;
        LOAD_VALID = 1'b1;
        tick();
        LOAD_VALID = 1'b0;
        check("ready_drop", 32'(LOAD_READY), 0);
        check("digit_midframe", 32'(DIGIT), 0);
        i = 0;
        while (DIGIT != 4'd1 && i < 100) begin
            tick();
            i++;
        end
        check("load_digit", 32'(DIGIT), 1);
        check("load_at_frame", age % 80, 0);
        tick();
        check("ready_back", 32'(LOAD_READY), 1);
        repeat (2) tick();
        check("col0_d1_raw", 32'(DOT_RAW), 32'(14'b1110011_1110011));

        LOAD_DIGIT = 4'd12;
        LOAD_VALID = 1'b1;
        tick();
        LOAD_VALID = 1'b0;
        check("load_err", 32'(LOAD_ERR), 1);
        check("err_ready", 32'(LOAD_READY), 1);
        check("err_digit", 32'(DIGIT), 1);
        tick();
        check("err_pulse_len", 32'(LOAD_ERR), 0);

        while (age % 8 != 4) tick();
        LOAD_DIGIT = 4'd7;
        LOAD_VALID = 1'b1;
        tick();
        LOAD_VALID = 1'b0;
        tick();
        RESET = 1'b1;
        tick();
        check("rst_col", 32'(DOT_COL), 0);
        check("rst_raw", 32'(DOT_RAW), 32'h3FFF);
        check("rst_digit", 32'(DIGIT), 0);
        check("rst_ready", 32'(LOAD_READY), 0);
        RESET = 1'b0;
        repeat (100) tick();
        check("rst_pend_gone", 32'(DIGIT), 0);

        repeat (4000) begin
            if ($urandom % 300 == 0) MODE = 2'($urandom_range(0, 3));
            PAUSE = ($urandom % 10 == 0);
            LOAD_VALID = ($urandom % 6 == 0);
            LOAD_DIGIT = 4'($urandom_range(0, 15));
            RESET = ($urandom % 1500 == 0);
            tick();
        end
        RESET = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
